me_fetch_ctrl: RTL and testbench
================================

Name: me_fetch_ctrl

Overview:
- Sequencing controller for the motion-estimation datapath. One search runs per start command.
- Fetches the 8x8 current block as 8 rows of 8 pixels (64 bits each) from the frame buffer.
- Fetches the 23x23 reference window as 23 rows of 23 pixels (184 bits each).
- Then enables SAD computation for a fixed number of cycles and hands the 16x16x2 int8 result downstream with a valid/ready handshake.
- Sits between the frame-buffer read port and the ME datapath. The controller carries no pixel data; it only issues requests and strobes.

Parameters:
- CUR_ROWS, 8, current-block rows to fetch.
- REF_ROWS, 23, reference-window rows to fetch.
- CALC_CYCLES, 16, cycles calc_en_o is held high.
- MAX_OUTST, 4, maximum granted-but-unreturned row requests (1..15).
- ROW_W, 5, width of row index outputs; must hold REF_ROWS-1.
- POS_W, 8, width of block coordinate fields.

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- blk_x_i  in  POS_W  block column, captured with start.
- blk_y_i  in  POS_W  block row, captured with start.
- blk_x_o  out  POS_W  latched block column.
- blk_y_o  out  POS_W  latched block row.
- busy_o  out  1  high in every state except IDLE.
- mem_req_o  out  1  row read request.
- mem_sel_o  out  1  0 = current block, 1 = reference window.
- mem_row_o  out  ROW_W  row index of the pending request.
- mem_gnt_i  in  1  request accepted when mem_req_o and mem_gnt_i are both high.
- mem_rvalid_i  in  1  one row of data returned, in order.
- cur_we_o  out  1  datapath writes current row cur_row_o.
- cur_row_o  out  ROW_W  current-row write index.
- ref_we_o  out  1  datapath writes reference row ref_row_o.
- ref_row_o  out  ROW_W  reference-row write index.
- calc_en_o  out  1  datapath compute enable.
- calc_cnt_o  out  ROW_W  compute step index.
- res_valid_o  out  1  me_result valid.
- res_ready_i  in  1  downstream accepts the result.
- done_o  out  1  single-cycle pulse on the result handshake.
- err_o  out  1  sticky: mem_rvalid_i seen with nothing outstanding.

Behaviour:
- Reset: state IDLE, all counters 0, every output 0.
- States: IDLE -> FETCH_CUR -> FETCH_REF -> COMPUTE -> RESULT -> IDLE.
- IDLE:
  - start_i=1 latches blk_x_i/blk_y_i and clears issued and returned counters.
  - Next state FETCH_CUR.
  - start_i while busy_o=1 is ignored.
- Fetch states:
  - mem_req_o = (issued < ROWS) && (issued - returned < MAX_OUTST), where ROWS is CUR_ROWS or REF_ROWS.
  - mem_row_o = issued; mem_sel_o = 0 in FETCH_CUR, 1 in FETCH_REF.
  - Each grant increments issued.
  - Each mem_rvalid_i increments returned and is combinationally forwarded: cur_we_o or ref_we_o = mem_rvalid_i, with cur_row_o/ref_row_o = returned.
  - Grant and rvalid may occur in the same cycle; both counters update.
  - mem_req_o is held until granted; mem_row_o is stable while ungranted.
- Phase transitions:
  - Leave a fetch state on the edge after returned reaches ROWS.
  - Counters are cleared on entry to FETCH_REF.
  - No reference requests are issued before all current rows have returned.
- COMPUTE:
  - calc_en_o=1 for exactly CALC_CYCLES cycles; calc_cnt_o counts 0..CALC_CYCLES-1.
  - Then go to RESULT.
- RESULT:
  - res_valid_o=1, held until res_ready_i=1.
  - On the handshake cycle done_o=1; next state IDLE.
  - start_i in that same cycle is ignored.
- err_o:
  - Set when mem_rvalid_i=1 and issued == returned, or when the state is IDLE/COMPUTE/RESULT.
  - The stray rvalid is ignored: no write strobe, no counter change.
  - Cleared only by reset.
- Reset mid-operation: immediate return to IDLE. Outputs drop asynchronously; in-flight memory returns after reset count as stray.
- Latency, with mem_gnt_i=1 and rvalid one cycle after grant; start at cycle 0:
  - Current-block requests in cycles 1..8.
  - FETCH_REF begins at cycle 10.
  - COMPUTE runs cycles 34..49.
  - res_valid_o rises at cycle 50.

Optional Feature:
- Macro: ME_FETCH_CTRL_PERF_EN.
- When defined:
  - Adds output perf_cycles_o [15:0], a saturating count of cycles from start acceptance (exclusive) to the result handshake (inclusive).
  - Updated on done_o and held otherwise; reset to 0.
- When undefined: the port and the counter do not exist.

Test Plan:
- Ideal memory (gnt=1, rvalid one cycle after grant), start at cycle 0, res_ready_i=1:
  - 8 cur_we_o pulses with rows 0..7 in cycles 2..9.
  - 23 ref_we_o pulses in cycles 11..33.
  - calc_en_o in cycles 34..49.
  - res_valid_o and done_o in cycle 50; perf_cycles_o=50.
- Backpressure: mem_gnt_i=1 but rvalid delayed 10 cycles -> never more than 4 unreturned requests; mem_row_o stays stable while ungranted.
- Result stall: res_ready_i=0 for 5 cycles in RESULT -> res_valid_o held high; done_o pulses exactly once when ready rises.
- start_i pulsed during FETCH_REF -> ignored; blk_x_o/blk_y_o unchanged; exactly one done_o.
- Stray mem_rvalid_i in IDLE -> err_o=1 and stays 1; no cur_we_o/ref_we_o pulse.
- rst_i asserted mid-FETCH_REF -> all outputs 0 immediately; the next start runs a full, correct sequence.

Source files
------------

// File: rtl/me_fetch_ctrl.sv
// Sequencer for the motion-estimation datapath: fetch current block, fetch reference window,
// run SAD compute, hand off result. Define ME_FETCH_CTRL_PERF_EN to add perf_cycles_o.
module me_fetch_ctrl #(
  parameter int CUR_ROWS    = 8,
  parameter int REF_ROWS    = 23,
  parameter int CALC_CYCLES = 16,
  parameter int MAX_OUTST   = 4,
  parameter int ROW_W       = 5,
  parameter int POS_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [POS_W-1:0] blk_x_i,
  input  logic [POS_W-1:0] blk_y_i,
  output logic [POS_W-1:0] blk_x_o,
  output logic [POS_W-1:0] blk_y_o,
  output logic             busy_o,
  output logic             mem_req_o,
  output logic             mem_sel_o,
  output logic [ROW_W-1:0] mem_row_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  output logic             cur_we_o,
  output logic [ROW_W-1:0] cur_row_o,
  output logic             ref_we_o,
  output logic [ROW_W-1:0] ref_row_o,
  output logic             calc_en_o,
  output logic [ROW_W-1:0] calc_cnt_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             done_o,
  output logic             err_o
`ifdef ME_FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]      perf_cycles_o
`endif
);

  // One extra bit so the issue counter can reach the row count itself.
  localparam int CNT_W = ROW_W + 1;
  localparam logic [CNT_W-1:0] CUR_N     = CNT_W'(CUR_ROWS);
  localparam logic [CNT_W-1:0] REF_N     = CNT_W'(REF_ROWS);
  localparam logic [CNT_W-1:0] OUT_N     = CNT_W'(MAX_OUTST);
  localparam logic [ROW_W-1:0] CALC_LAST = ROW_W'(CALC_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_CUR,
    ST_FETCH_REF,
    ST_COMPUTE,
    ST_RESULT
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] issued_reg;
  logic [CNT_W-1:0] returned_reg;
  logic [ROW_W-1:0] calc_cnt_reg;
  logic [POS_W-1:0] blk_x_reg;
  logic [POS_W-1:0] blk_y_reg;
  logic             err_reg;

  logic             in_fetch;
  logic             grant;
  logic             accept;
  logic             last_ret;
  logic [CNT_W-1:0] rows;
  logic [CNT_W-1:0] outstanding;

  always_comb begin
    in_fetch    = (state_reg == ST_FETCH_CUR) || (state_reg == ST_FETCH_REF);
    rows        = (state_reg == ST_FETCH_REF) ? REF_N : CUR_N;
    outstanding = issued_reg - returned_reg;
    mem_req_o   = in_fetch && (issued_reg < rows) && (outstanding < OUT_N);
    grant       = mem_req_o && mem_gnt_i;
    // A return with nothing outstanding is stray and must not move any counter.
    accept      = in_fetch && mem_rvalid_i && (issued_reg != returned_reg);
    last_ret    = accept && (returned_reg == rows - CNT_W'(1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      issued_reg   <= '0;
      returned_reg <= '0;
      calc_cnt_reg <= '0;
      blk_x_reg    <= '0;
      blk_y_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (mem_rvalid_i && !accept) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            blk_x_reg    <= blk_x_i;
            blk_y_reg    <= blk_y_i;
            issued_reg   <= '0;
            returned_reg <= '0;
            state_reg    <= ST_FETCH_CUR;
          end
        end
        ST_FETCH_CUR, ST_FETCH_REF: begin
          if (last_ret) begin
            issued_reg   <= '0;
            returned_reg <= '0;
            state_reg    <= (state_reg == ST_FETCH_CUR) ? ST_FETCH_REF : ST_COMPUTE;
          end else begin
            if (grant) begin
              issued_reg <= issued_reg + CNT_W'(1);
            end
            if (accept) begin
              returned_reg <= returned_reg + CNT_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (calc_cnt_reg == CALC_LAST) begin
            calc_cnt_reg <= '0;
            state_reg    <= ST_RESULT;
          end else begin
            calc_cnt_reg <= calc_cnt_reg + ROW_W'(1);
          end
        end
        ST_RESULT: begin
          if (res_ready_i) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign blk_x_o     = blk_x_reg;
  assign blk_y_o     = blk_y_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign mem_sel_o   = (state_reg == ST_FETCH_REF);
  assign mem_row_o   = issued_reg[ROW_W-1:0];
  assign cur_we_o    = accept && (state_reg == ST_FETCH_CUR);
  assign cur_row_o   = (state_reg == ST_FETCH_CUR) ? returned_reg[ROW_W-1:0] : '0;
  assign ref_we_o    = accept && (state_reg == ST_FETCH_REF);
  assign ref_row_o   = (state_reg == ST_FETCH_REF) ? returned_reg[ROW_W-1:0] : '0;
  assign calc_en_o   = (state_reg == ST_COMPUTE);
  assign calc_cnt_o  = calc_cnt_reg;
  assign res_valid_o = (state_reg == ST_RESULT);
  assign done_o      = (state_reg == ST_RESULT) && res_ready_i;
  assign err_o       = err_reg;

`ifdef ME_FETCH_CTRL_PERF_EN
  logic [15:0] perf_cnt_reg;
  logic [15:0] perf_out_reg;
  logic [15:0] perf_inc;

  // Counts busy cycles; the handshake cycle itself is included via perf_inc.
  assign perf_inc = (perf_cnt_reg == 16'hFFFF) ? perf_cnt_reg : perf_cnt_reg + 16'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt_reg <= '0;
      perf_out_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      if (start_i) begin
        perf_cnt_reg <= '0;
      end
    end else begin
      perf_cnt_reg <= perf_inc;
      if (done_o) begin
        perf_out_reg <= perf_inc;
      end
    end
  end

  assign perf_cycles_o = perf_out_reg;
`endif

endmodule

// File: tb/tb_me_fetch_ctrl.sv
// Self-checking bench for me_fetch_ctrl: phase-level reference model, randomized memory
// latency/grant/ready, plus directed timing, backpressure, stall, restart and reset steps.
module tb_me_fetch_ctrl;
  localparam int CUR_ROWS    = 8;
  localparam int REF_ROWS    = 23;
  localparam int CALC_CYCLES = 16;
  localparam int MAX_OUTST   = 4;
  localparam int ROW_W       = 5;
  localparam int POS_W       = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [POS_W-1:0] blk_x_i = '0;
  logic [POS_W-1:0] blk_y_i = '0;
  logic             mem_gnt_i = 1'b0;
  logic             mem_rvalid_i = 1'b0;
  logic             res_ready_i = 1'b0;
  logic [POS_W-1:0] blk_x_o, blk_y_o;
  logic             busy_o, mem_req_o, mem_sel_o, cur_we_o, ref_we_o;
  logic             calc_en_o, res_valid_o, done_o, err_o;
  logic [ROW_W-1:0] mem_row_o, cur_row_o, ref_row_o, calc_cnt_o;
`ifdef ME_FETCH_CTRL_PERF_EN
  logic [15:0]      perf_cycles_o;
`endif

  always #5 clk_i = ~clk_i;

  me_fetch_ctrl #(
    .CUR_ROWS(CUR_ROWS), .REF_ROWS(REF_ROWS), .CALC_CYCLES(CALC_CYCLES),
    .MAX_OUTST(MAX_OUTST), .ROW_W(ROW_W), .POS_W(POS_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .blk_x_i(blk_x_i), .blk_y_i(blk_y_i), .blk_x_o(blk_x_o), .blk_y_o(blk_y_o),
    .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_sel_o(mem_sel_o), .mem_row_o(mem_row_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .cur_we_o(cur_we_o), .cur_row_o(cur_row_o), .ref_we_o(ref_we_o), .ref_row_o(ref_row_o),
    .calc_en_o(calc_en_o), .calc_cnt_o(calc_cnt_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .done_o(done_o), .err_o(err_o)
`ifdef ME_FETCH_CTRL_PERF_EN
    , .perf_cycles_o(perf_cycles_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  // Memory model: due cycles of granted rows, returned strictly in order.
  int pend[$];
  int last_due = 0;
  int gnt_mode = 0, lat_min = 1, lat_max = 1, ready_mode = 0;
  bit drv_start = 0, drv_stray = 0, inj_start = 0;
  logic [POS_W-1:0] drv_x = '0, drv_y = '0;

  // Reference model: phase 0 idle, 1 current fetch, 2 reference fetch, 3 compute, 4 result.
  int ph = 0, n_iss = 0, n_ret = 0, calc_k = 0, res_wait = 0, start_cyc = 0;
  bit exp_err = 0;
  logic [POS_W-1:0] exp_x = '0, exp_y = '0;

  // Per-run observations taken straight from DUT strobes.
  int n_cur, n_ref, n_calc, n_done, n_inj;
  int first_cur, last_cur, first_ref, last_ref, first_calc, last_calc, done_cyc;
  int out_obs, max_out;
  bit prev_stall = 0;
  logic [ROW_W-1:0] prev_row = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    int  rows, lat, due;
    bit  req_e, acc, gnt, rv, inj;
    @(posedge clk_i);
    #1;
    rv = 1'b0;
    if (pend.size() > 0 && pend[0] <= cyc_n) begin
      rv = 1'b1;
      void'(pend.pop_front());
    end
    if (drv_stray) rv = 1'b1;
    mem_rvalid_i = rv;
    gnt = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    mem_gnt_i = gnt;
    inj = inj_start && (ph == 2);
    start_i = drv_start || inj;
    blk_x_i = inj ? ~drv_x : drv_x;
    blk_y_i = inj ? ~drv_y : drv_y;
    res_ready_i = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (res_wait >= 5);
    #1;
    rows  = (ph == 2) ? REF_ROWS : CUR_ROWS;
    req_e = (ph == 1 || ph == 2) && n_iss < rows && (n_iss - n_ret) < MAX_OUTST;
    acc   = (ph == 1 || ph == 2) && rv && (n_iss != n_ret);
    chk("busy", 32'(busy_o), 32'(ph != 0));
    chk("mem_req", 32'(mem_req_o), 32'(req_e));
    if (req_e) begin
      chk("mem_sel", 32'(mem_sel_o), 32'(ph == 2));
      chk("mem_row", 32'(mem_row_o), 32'(n_iss));
    end
    chk("cur_we", 32'(cur_we_o), 32'(acc && ph == 1));
    chk("ref_we", 32'(ref_we_o), 32'(acc && ph == 2));
    if (acc && ph == 1) chk("cur_row", 32'(cur_row_o), 32'(n_ret));
    if (acc && ph == 2) chk("ref_row", 32'(ref_row_o), 32'(n_ret));
    chk("calc_en", 32'(calc_en_o), 32'(ph == 3));
    if (ph == 3) chk("calc_cnt", 32'(calc_cnt_o), 32'(calc_k));
    chk("res_valid", 32'(res_valid_o), 32'(ph == 4));
    chk("done", 32'(done_o), 32'(ph == 4 && res_ready_i));
    chk("err", 32'(err_o), 32'(exp_err));
    chk("blk_x", 32'(blk_x_o), 32'(exp_x));
    chk("blk_y", 32'(blk_y_o), 32'(exp_y));
    if (prev_stall) begin
      chk("req_held", 32'(mem_req_o), 32'(1));
      chk("row_held", 32'(mem_row_o), 32'(prev_row));
    end
    prev_stall = mem_req_o && !gnt;
    prev_row   = mem_row_o;
    // Observations for per-run summaries.
    if (inj) n_inj++;
    if (cur_we_o) begin if (n_cur == 0) first_cur = cyc_n; last_cur = cyc_n; n_cur++; end
    if (ref_we_o) begin if (n_ref == 0) first_ref = cyc_n; last_ref = cyc_n; n_ref++; end
    if (calc_en_o) begin if (n_calc == 0) first_calc = cyc_n; last_calc = cyc_n; n_calc++; end
    if (done_o) begin n_done++; done_cyc = cyc_n; end
    out_obs = out_obs + int'(mem_req_o && gnt) - int'(cur_we_o || ref_we_o);
    if (out_obs > max_out) max_out = out_obs;
    // Memory accepts whatever the DUT actually requested.
    if (mem_req_o && gnt) begin
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc_n + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back(due);
    end
    // Model update from the spec's phase rules.
    exp_err = exp_err | (rv && !acc);
    case (ph)
      0: if (start_i) begin
           ph = 1; n_iss = 0; n_ret = 0; exp_x = blk_x_i; exp_y = blk_y_i; start_cyc = cyc_n;
         end
      1, 2: begin
        if (req_e && gnt) n_iss++;
        if (acc) n_ret++;
        if (n_ret == rows) begin ph++; n_iss = 0; n_ret = 0; calc_k = 0; end
      end
      3: begin calc_k++; if (calc_k == CALC_CYCLES) begin ph = 4; res_wait = 0; end end
      4: if (res_ready_i) ph = 0; else res_wait++;
      default: ph = 0;
    endcase
    drv_stray = 1'b0;
    cyc_n++;
  endtask

  task automatic run(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y, input bit ideal);
    int budget;
    n_cur = 0; n_ref = 0; n_calc = 0; n_done = 0; n_inj = 0;
    out_obs = 0; max_out = 0; done_cyc = 0;
    drv_x = x; drv_y = y; drv_start = 1'b1;
    cyc();
    drv_start = 1'b0;
    budget = 0;
    while (n_done == 0 && budget < 3000) begin cyc(); budget++; end
    chk("run_completed", 32'(n_done != 0), 32'(1));
    cyc();
    $display("run x=%0d y=%0d: cur=%0d ref=%0d calc=%0d done=%0d latency=%0d max_out=%0d",
             x, y, n_cur, n_ref, n_calc, n_done, done_cyc - start_cyc, max_out);
    chk("n_cur", 32'(n_cur), 32'(CUR_ROWS));
    chk("n_ref", 32'(n_ref), 32'(REF_ROWS));
    chk("n_calc", 32'(n_calc), 32'(CALC_CYCLES));
    chk("n_done", 32'(n_done), 32'(1));
    chk("max_out_le", 32'(max_out <= MAX_OUTST), 32'(1));
    chk("blk_x_run", 32'(blk_x_o), 32'(x));
    chk("blk_y_run", 32'(blk_y_o), 32'(y));
    if (ideal) begin
      chk("t_first_cur", 32'(first_cur - start_cyc), 32'(2));
      chk("t_last_cur", 32'(last_cur - start_cyc), 32'(9));
      chk("t_first_ref", 32'(first_ref - start_cyc), 32'(11));
      chk("t_last_ref", 32'(last_ref - start_cyc), 32'(33));
      chk("t_first_calc", 32'(first_calc - start_cyc), 32'(34));
      chk("t_last_calc", 32'(last_calc - start_cyc), 32'(49));
      chk("t_done", 32'(done_cyc - start_cyc), 32'(50));
    end
`ifdef ME_FETCH_CTRL_PERF_EN
    chk("perf_cycles", 32'(perf_cycles_o), 32'(done_cyc - start_cyc));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int budget;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_req", 32'(mem_req_o), 32'(0));
    chk("rst_calc", 32'(calc_en_o), 32'(0));
    chk("rst_valid", 32'(res_valid_o), 32'(0));
    chk("rst_err", 32'(err_o), 32'(0));
    chk("rst_row", 32'(mem_row_o), 32'(0));
    rst_i = 1'b0;
    idle(2);

    // Ideal memory: absolute timing.
    gnt_mode = 0; lat_min = 1; lat_max = 1; ready_mode = 0;
    run(8'd12, 8'd34, 1'b1);
    idle(2);

    // Slow returns with full grant: outstanding limit must be reached but never exceeded.
    lat_min = 10; lat_max = 10;
    run(8'd5, 8'd6, 1'b0);
    chk("max_out_hit", 32'(max_out), 32'(MAX_OUTST));
    idle(2);

    // Result stall: ready held low for 5 cycles in RESULT.
    lat_min = 1; lat_max = 3; ready_mode = 2;
    run(8'd77, 8'd88, 1'b0);
    idle(2);

    // Start pulses with other coordinates throughout FETCH_REF are ignored.
    ready_mode = 0; inj_start = 1'b1;
    run(8'd100, 8'd200, 1'b0);
    inj_start = 1'b0;
    chk("inj_pulsed", 32'(n_inj > 0), 32'(1));
    idle(2);

    // Random grant, latency and ready.
    gnt_mode = 1; lat_min = 1; lat_max = 6; ready_mode = 1;
    for (int r = 0; r < 3; r++) begin
      run(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b0);
      idle(int'($urandom_range(3, 0)));
    end

    // Stray return in IDLE sets the sticky error, with no write strobe.
    gnt_mode = 0; ready_mode = 0;
    drv_stray = 1'b1;
    cyc();
    idle(3);
    chk("err_sticky", 32'(err_o), 32'(1));

    // Reset in the middle of FETCH_REF.
    lat_min = 3; lat_max = 5;
    drv_x = 8'd9; drv_y = 8'd10; drv_start = 1'b1;
    cyc();
    drv_start = 1'b0;
    budget = 0;
    while (!(ph == 2 && n_iss >= 3) && budget < 500) begin cyc(); budget++; end
    chk("reached_fetch_ref", 32'(ph), 32'(2));
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 32'(0));
    chk("mid_rst_req", 32'(mem_req_o), 32'(0));
    chk("mid_rst_sel", 32'(mem_sel_o), 32'(0));
    chk("mid_rst_ref_we", 32'(ref_we_o), 32'(0));
    chk("mid_rst_ref_row", 32'(ref_row_o), 32'(0));
    chk("mid_rst_err", 32'(err_o), 32'(0));
    chk("mid_rst_blk_x", 32'(blk_x_o), 32'(0));
    ph = 0; n_iss = 0; n_ret = 0; calc_k = 0; exp_err = 0;
    exp_x = '0; exp_y = '0; prev_stall = 0;
    start_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    idle(15);
    chk("stray_after_rst", 32'(err_o), 32'(1));
    lat_min = 1; lat_max = 1;
    run(8'd42, 8'd43, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
